// File: rtl/sys_mem_model.sv
// sys_mem_model: byte-addressed system memory behind the processor memory interface.
// Serves one 16-bit little-endian read or write at a time after a fixed LATENCY, then
// holds mem_resp until the requester drops its request.
// Optional: define SYS_MEM_CLEAR_EN to zero the whole array after every reset
// (init_busy high during the sweep, one 16-bit word per cycle).
module sys_mem_model #(
  parameter int unsigned LATENCY = 4,   // 1..15
  parameter int unsigned ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addrout,
  input  logic [15:0]       datatomem,
  output logic [15:0]       datafrommem,
  output logic              mem_resp,
  output logic              req_err,
  output logic              init_busy
);

  localparam int unsigned     Depth   = 2 ** ADDR_W;
  localparam int unsigned     CntW    = 4;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StInit} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              wr_q;
  logic [15:0]       datafrommem_q;
  logic              mem_resp_q;
  logic              req_err_q;

  logic [7:0]        mem [Depth];

  logic              mem_we;
  logic [ADDR_W-1:0] we_addr_lo;
  logic [ADDR_W-1:0] we_addr_hi;
  logic [15:0]       we_data;
  logic [ADDR_W-1:0] rd_addr_hi;

`ifdef SYS_MEM_CLEAR_EN
  logic              init_busy_q;
  logic [ADDR_W-2:0] init_ptr_q;
  localparam logic [ADDR_W-2:0] PtrOne = (ADDR_W-1)'(1);
`endif

  // Select the array write port: clear sweep or the completing write access.
  always_comb begin
    mem_we     = 1'b0;
    we_addr_lo = addr_q;
    we_data    = wdata_q;
    if (state_q == StBusy && cnt_q == '0 && wr_q) begin
      mem_we = 1'b1;
    end
`ifdef SYS_MEM_CLEAR_EN
    if (state_q == StInit) begin
      mem_we     = 1'b1;
      we_addr_lo = {init_ptr_q, 1'b0};
      we_data    = 16'h0000;
    end
`endif
  end

  // Upper byte wraps to address 0 at the top of the array.
  assign we_addr_hi = we_addr_lo + AddrOne;
  assign rd_addr_hi = addr_q + AddrOne;

  // Array write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[we_addr_lo] <= we_data[7:0];
      mem[we_addr_hi] <= we_data[15:8];
    end
  end

  // Request FSM with registered outputs; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef SYS_MEM_CLEAR_EN
      state_q     <= StInit;
      init_busy_q <= 1'b1;
      init_ptr_q  <= '0;
`else
      state_q     <= StIdle;
`endif
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      datafrommem_q <= '0;
      mem_resp_q    <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cs && (read_req || write_req)) begin
            addr_q    <= addrout;
            wdata_q   <= datatomem;
            // A conflicting request is served as a write.
            wr_q      <= write_req;
            req_err_q <= read_req && write_req;
            cnt_q     <= CntLoad;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            if (!wr_q) begin
              datafrommem_q <= {mem[rd_addr_hi], mem[addr_q]};
            end
            mem_resp_q <= 1'b1;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StResp: begin
          if (!read_req && !write_req) begin
            mem_resp_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StInit: begin
`ifdef SYS_MEM_CLEAR_EN
          init_ptr_q <= init_ptr_q + PtrOne;
          if (init_ptr_q == '1) begin
            init_busy_q <= 1'b0;
            state_q     <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign datafrommem = datafrommem_q;
  assign mem_resp    = mem_resp_q;
  assign req_err     = req_err_q;
`ifdef SYS_MEM_CLEAR_EN
  assign init_busy   = init_busy_q;
`else
  assign init_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_sys_mem_model.sv
// Testbench for sys_mem_model: directed scenarios plus random transactions checked
// against a byte-array reference model with per-byte "known" flags.
module tb_sys_mem_model;

  localparam int unsigned AW    = 14;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cs = 1'b0, read_req = 1'b0, write_req = 1'b0;
  logic [AW-1:0] addrout = '0;
  logic [15:0]   datatomem = '0;
  logic [15:0]   datafrommem;
  logic          mem_resp, req_err, init_busy;

  logic          cs1 = 1'b0, read_req1 = 1'b0, write_req1 = 1'b0;
  logic [AW-1:0] addrout1 = '0;
  logic [15:0]   datatomem1 = '0;
  logic [15:0]   datafrommem1;
  logic          mem_resp1, req_err1, init_busy1;

  always #5 clk = ~clk;

  sys_mem_model #(.LATENCY(LAT), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read_req(read_req), .write_req(write_req),
    .addrout(addrout), .datatomem(datatomem), .datafrommem(datafrommem),
    .mem_resp(mem_resp), .req_err(req_err), .init_busy(init_busy)
  );

  sys_mem_model #(.LATENCY(1), .ADDR_W(AW)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .cs(cs1), .read_req(read_req1), .write_req(write_req1),
    .addrout(addrout1), .datatomem(datatomem1), .datafrommem(datafrommem1),
    .mem_resp(mem_resp1), .req_err(req_err1), .init_busy(init_busy1)
  );

  // Reference model: what each byte should hold, and whether it is known at all.
  logic [7:0] model [DEPTH];
  bit         known [DEPTH];
  logic [15:0] last_rd;
  bit   [1:0]  last_known;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
`ifdef SYS_MEM_CLEAR_EN
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 9000) begin
      tick();
      n++;
    end
    chk("init_cycles", n, 8192);
    for (int i = 0; i < int'(DEPTH); i++) begin
      model[i] = 8'h00;
      known[i] = 1'b1;
    end
`else
    chk("init_busy_tied", {31'd0, init_busy}, 0);
`endif
  endtask

  task automatic release_reset();
    cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
    #20;
    reset_n = 1'b1;
    last_rd = 16'h0000;
    last_known = 2'b11;
    chk("rst_rdata", {16'd0, datafrommem}, 0);
    chk("rst_resp", {31'd0, mem_resp}, 0);
    chk("rst_err", {31'd0, req_err}, 0);
    wait_init();
  endtask

  // One complete handshake; inputs are scrambled after acceptance to prove they are ignored.
  task automatic access(input bit w, input bit r, input logic [AW-1:0] a,
                        input logic [15:0] d, input int hold);
    int lat;
    logic [AW-1:0] ah;
    ah = a + 14'd1;
    cs = 1'b1; write_req = w; read_req = r; addrout = a; datatomem = d;
    tick();
    chk("req_err_pulse", {31'd0, req_err}, {31'd0, w && r});
    addrout = 14'($urandom);
    datatomem = 16'($urandom);
    cs = 1'($urandom_range(0, 1));
    lat = 0;
    while (mem_resp !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) chk("req_err_clear", {31'd0, req_err}, 0);
    end
    chk("latency", lat, LAT);
    if (w) begin
      model[a] = d[7:0];   known[a] = 1'b1;
      model[ah] = d[15:8]; known[ah] = 1'b1;
      if (last_known[0]) chk("rd_hold_lo", {24'd0, datafrommem[7:0]}, {24'd0, last_rd[7:0]});
      if (last_known[1]) chk("rd_hold_hi", {24'd0, datafrommem[15:8]}, {24'd0, last_rd[15:8]});
    end else begin
      last_rd = {model[ah], model[a]};
      last_known = {known[ah], known[a]};
      if (known[a])  chk("rd_lo", {24'd0, datafrommem[7:0]}, {24'd0, model[a]});
      if (known[ah]) chk("rd_hi", {24'd0, datafrommem[15:8]}, {24'd0, model[ah]});
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("resp_hold", {31'd0, mem_resp}, 1);
    end
    read_req = 1'b0; write_req = 1'b0;
    tick();
    chk("resp_fall", {31'd0, mem_resp}, 0);
  endtask

  initial begin
    int lat;
    logic [AW-1:0] ra;
    for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
    last_rd = 16'h0000;
    last_known = 2'b11;

    #2;
    reset_n = 1'b0;
    release_reset();

    // Write then read, including an odd-address read.
    access(1'b1, 1'b0, 14'h0010, 16'hBEEF, 0);
    access(1'b0, 1'b1, 14'h0010, 16'h0000, 0);
    access(1'b0, 1'b1, 14'h0011, 16'h0000, 0);

    // Top-of-array wrap.
    access(1'b1, 1'b0, 14'h3FFF, 16'h1234, 0);
    access(1'b0, 1'b1, 14'h0000, 16'h0000, 1);
    access(1'b0, 1'b1, 14'h3FFF, 16'h0000, 0);

    // Long hold of the read request.
    access(1'b0, 1'b1, 14'h0010, 16'h0000, 6);

    // Conflicting request is served as a write.
    access(1'b1, 1'b1, 14'h0100, 16'h00AA, 0);
    access(1'b0, 1'b1, 14'h0100, 16'h0000, 0);

    // cs low: request must be ignored.
    cs = 1'b0; read_req = 1'b1; addrout = 14'h0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("cs_gate", {31'd0, mem_resp}, 0);
    end
    read_req = 1'b0;
    tick();

    // Reset in the middle of a write aborts it.
    access(1'b1, 1'b0, 14'h0200, 16'hA5C3, 0);
    cs = 1'b1; write_req = 1'b1; addrout = 14'h0200; datatomem = 16'h5555;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_resp", {31'd0, mem_resp}, 0);
    release_reset();
    access(1'b0, 1'b1, 14'h0200, 16'h0000, 0);

    // Reset while mem_resp is high drops it immediately.
    cs = 1'b1; read_req = 1'b1; addrout = 14'h0010;
    lat = 0;
    while (mem_resp !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("resp_before_rst", {31'd0, mem_resp}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_in_resp", {31'd0, mem_resp}, 0);
    release_reset();

    // Random traffic, mostly in a small window so reads hit earlier writes.
    for (int t = 0; t < 40; t++) begin
      int op;
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ra = 14'h3FFE + 14'($urandom_range(0, 1));
      else ra = 14'h0400 + 14'($urandom_range(0, 15));
      if (op == 0)      access(1'b1, 1'b1, ra, 16'($urandom), int'($urandom_range(0, 3)));
      else if (op < 4)  access(1'b1, 1'b0, ra, 16'($urandom), int'($urandom_range(0, 3)));
      else              access(1'b0, 1'b1, ra, 16'($urandom), int'($urandom_range(0, 3)));
    end

    // LATENCY=1 instance: response one cycle after acceptance.
    cs1 = 1'b1; write_req1 = 1'b1; addrout1 = 14'h0123; datatomem1 = 16'hC0DE;
    tick();
    chk("lat1_wr_accept", {31'd0, mem_resp1}, 0);
    tick();
    chk("lat1_wr_resp", {31'd0, mem_resp1}, 1);
    write_req1 = 1'b0;
    tick();
    chk("lat1_wr_fall", {31'd0, mem_resp1}, 0);
    read_req1 = 1'b1;
    tick();
    tick();
    chk("lat1_rd_resp", {31'd0, mem_resp1}, 1);
    chk("lat1_rd_data", {16'd0, datafrommem1}, 32'h0000C0DE);
    read_req1 = 1'b0;
    tick();
    chk("lat1_rd_fall", {31'd0, mem_resp1}, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/sys_mem_model.md
Name: sys_mem_model

Overview:
- Downstream stage of the processor memory interface: the 16 KB system memory (MSS) that serves its read/write requests.
- Accepts one request at a time qualified by cs. Holds it for a fixed access latency, performs the access, then raises mem_resp until the requester drops its request.
- Byte-addressed storage; 16-bit transfers, little-endian.

Parameters:
- LATENCY, 4, cycles from request acceptance to mem_resp rising (legal 1..15)
- ADDR_W, 14, byte address width (depth = 2**ADDR_W bytes)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cs  in  1  chip select; requests ignored when low
- read_req  in  1  read request
- write_req  in  1  write request
- addrout  in  ADDR_W  byte address of access
- datatomem  in  16  write data
- datafrommem  out  16  read data
- mem_resp  out  1  access complete / response
- req_err  out  1  one-cycle pulse: read_req and write_req both high at acceptance
- init_busy  out  1  memory clear sweep in progress (tied 0 without macro)

Behaviour:
- Reset (async, reset_n low): state=IDLE (or INIT with macro); mem_resp=0, datafrommem=0, req_err=0, latency counter=0, captured request cleared. Memory array is not reset.
- Reset mid-access aborts the access: no array write occurs, and mem_resp drops immediately.
- FSM states:
  - IDLE: accept when cs && (read_req || write_req) on a rising edge. Capture addrout, datatomem and op. Load counter with LATENCY-1, go to BUSY. When LATENCY=1, go straight to RESP on the next edge.
  - Both read_req and write_req high at acceptance: treated as a write; req_err=1 for exactly one cycle.
  - BUSY: decrement counter each cycle; input changes are ignored. When counter==0, perform the access and go to RESP with mem_resp=1.
  - mem_resp timing: first high in the cycle after edge N+LATENCY, where N is the acceptance edge.
  - RESP: hold mem_resp=1 while (read_req || write_req) is still high. On the first edge where both are low, mem_resp=0 and go to IDLE. A new request is accepted no earlier than the cycle after returning to IDLE.
- Write: mem[a] <= data[7:0]; mem[(a+1) mod 2**ADDR_W] <= data[15:8]. Address 0x3FFF wraps its upper byte to 0x0000.
- Read: datafrommem <= {mem[(a+1) mod depth], mem[a]}, loaded on the BUSY->RESP edge. It holds until the next read completes; writes do not change datafrommem.
- cs dropping during BUSY/RESP does not cancel the access; only request deassertion ends RESP.
- Back-to-back: requester re-asserting req in the same cycle mem_resp falls is seen as a new request in IDLE.

Optional Feature:
- Macro: SYS_MEM_CLEAR_EN
- With the macro:
  - After reset the FSM enters INIT with init_busy=1 and writes 16'h0000 to one 16-bit word (2 bytes) per cycle, from address 0 upward.
  - Sweep takes 2**(ADDR_W-1) cycles; then init_busy=0 and the FSM goes to IDLE.
  - Requests during INIT are not accepted and get no response; the requester must keep req high until served.
- Without the macro: no INIT state, init_busy tied 0, array contents undefined (X in simulation) until written.

Test Plan:
- Write then read: write 16'hBEEF to 0x0010 (cs=1), hold req until mem_resp -> mem_resp rises exactly 4 cycles after acceptance. Read 0x0010 -> datafrommem=16'hBEEF; byte read at 0x0011 returns 16'h??BE with low byte 0xBE.
- Wrap: write 16'h1234 to 0x3FFF -> mem[0x3FFF]=0x34, mem[0x0000]=0x12; read 0x0000 returns low byte 0x12.
- Hold/release: keep read_req high 6 cycles after mem_resp -> mem_resp stays 1 throughout and falls one edge after read_req drops. Change addrout during BUSY -> original address is served.
- Conflict: read_req=write_req=1, data 16'h00AA at 0x0100 -> req_err one-cycle pulse; later read of 0x0100 returns 16'h00AA.
- Reset mid-access: assert reset_n=0 during BUSY of a write of 16'h5555 to 0x0200 -> mem_resp=0 immediately; 0x0200 contents unchanged. With SYS_MEM_CLEAR_EN, a read of 0x0200 after the sweep returns 16'h0000 and init_busy is high for 8192 cycles.
- cs gating and LATENCY=1: req with cs=0 -> no response for 20 cycles. Rerun with LATENCY=1 -> mem_resp high one cycle after acceptance.
